// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - round-robin telemetry arbiter framing header+payload bytes into a UART transmitter
module uart_tx_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   ack,
    output logic [7:0]           tx_data,
    output logic                 tx_start,
    input  logic                 tx_busy,
    output logic [1:0]           grant_id,
    output logic                 sched_busy,
    output logic                 timeout_err
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, HDR, WAIT_HDR_HI, WAIT_HDR_LO, DATA, WAIT_DAT_HI, WAIT_DAT_LO
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]    last_id, winner, idx;
    logic          found, wait_hi, hit_timeout;
    logic [3:0]    req_pad, ack_r;
    logic [31:0]   data_pad;
    logic [7:0]    payload;

    // Pad to the maximum of four sources so all indexing uses fixed widths
    assign req_pad  = 4'(req);
    assign data_pad = 32'(req_data);

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = 2'((int'(last_id) + 1 + k) % NUM_REQ);
            if (!found && req_pad[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign wait_hi     = (state == WAIT_HDR_HI) || (state == WAIT_DAT_HI);
    // Fires on the ACK_TIMEOUT-th consecutive idle cycle of the transmitter
    assign hit_timeout = wait_hi && !tx_busy && (cnt == CW'(ACK_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: if (found) state_n = HDR;
            HDR: begin
                state_n = WAIT_HDR_HI;
                cnt_n   = '0;
            end
            DATA: begin
                state_n = WAIT_DAT_HI;
                cnt_n   = '0;
            end
            WAIT_HDR_HI, WAIT_DAT_HI: begin
                if (tx_busy) begin
                    state_n = (state == WAIT_HDR_HI) ? WAIT_HDR_LO : WAIT_DAT_LO;
                    cnt_n   = '0;
                end else if (hit_timeout) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt != CW'(ACK_TIMEOUT)) begin
                    cnt_n = cnt + 1'b1;
                end
            end
            WAIT_HDR_LO: if (!tx_busy) state_n = DATA;
            WAIT_DAT_LO: if (!tx_busy) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_id <= '0;
            last_id  <= 2'(NUM_REQ - 1);
            ack_r    <= '0;
            tx_data  <= '0;
            payload  <= '0;
        end else begin
            ack_r <= '0;
            if (state == IDLE && found) begin
                grant_id      <= winner;
                last_id       <= winner;
                payload       <= data_pad[{winner, 3'b000} +: 8];
                ack_r[winner] <= 1'b1;
                tx_data       <= {6'b101000, winner};
            end else if (state == WAIT_HDR_LO && !tx_busy) begin
                tx_data <= payload;
            end
        end
    end

    assign ack         = ack_r[NUM_REQ-1:0];
    assign tx_start    = (state == HDR) || (state == DATA);
    assign sched_busy  = (state != IDLE);
    assign timeout_err = hit_timeout;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - directed self-checking bench for uart_tx_scheduler
module tb_uart_tx_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [31:0] req_data = {8'hD3, 8'h3C, 8'h5B, 8'h71};
    logic [3:0]  ack;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic [1:0]  grant_id;
    logic        sched_busy;
    logic        timeout_err;

    int n_vec = 0;
    int n_miss = 0;
    int cyc = 0;
    int mode = 0;
    int start_cyc = 0;
    int to_cyc = 0;
    int to_count = 0;
    int stab_err = 0;
    logic       have_byte = 1'b0;
    logic [7:0] last_byte = '0;
    logic [7:0] sent[$];

    uart_tx_scheduler #(.NUM_REQ(4), .ACK_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .grant_id(grant_id), .sched_busy(sched_busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Transmitter model: busy rises 2 cycles after a start, held 10 (or 100) cycles
    initial begin
        int hold;
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst && tx_start && mode != 1) begin
                hold = (mode == 2) ? 100 : 10;
                repeat (2) @(negedge clk);
                tx_busy = 1'b1;
                repeat (hold) @(negedge clk);
                tx_busy = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            have_byte = 1'b0;
        end else begin
            if (tx_start) begin
                sent.push_back(tx_data);
                start_cyc = cyc;
                have_byte = 1'b1;
                last_byte = tx_data;
            end else if (sched_busy && have_byte && tx_data != last_byte) begin
                stab_err++;
            end
            if (timeout_err) begin
                to_cyc = cyc;
                to_count++;
            end
        end
    end

    task automatic wait_ack(input string tag, input int lim);
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (ack != 0) break;
        end
        check(tag, 32'(ack != 0), 32'd1);
    endtask

    task automatic wait_idle(input string tag, input int lim);
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (!sched_busy) break;
        end
        check(tag, 32'(sched_busy), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ack"}, 32'(ack), 32'd0);
        check({tag, "_txd"}, 32'(tx_data), 32'd0);
        check({tag, "_start"}, 32'(tx_start), 32'd0);
        check({tag, "_gid"}, 32'(grant_id), 32'd0);
        check({tag, "_busy"}, 32'(sched_busy), 32'd0);
        check({tag, "_terr"}, 32'(timeout_err), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int c0;
        int gid;
        #3 rst = 1'b0;
        #4 check_reset_vals("rst");
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Single frame from source 2
        @(negedge clk);
        c0  = cyc;
        req = 4'b0100;
        wait_ack("single_ack_wait", 10);
        check("single_ack_lat", 32'(cyc - c0), 32'd1);
        check("single_ack", 32'(ack), 32'h4);
        check("single_start_same", 32'(tx_start), 32'd1);
        req = '0;
        wait_idle("single_idle", 100);
        check("single_nbytes", 32'(sent.size()), 32'd2);
        if (sent.size() == 2) begin
            check("single_hdr", 32'(sent[0]), 32'hA2);
            check("single_dat", 32'(sent[1]), 32'h3C);
        end
        check("single_gid", 32'(grant_id), 32'd2);

        // Fairness: after reset the search starts at source 0
        do_reset();
        sent.delete();
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_ack("rr_ack_wait", 200);
            gid = int'(grant_id);
            check("rr_gid", 32'(gid), 32'(g % 4));
            check("rr_ack", 32'(ack), 32'(1 << (g % 4)));
            req[gid] = 1'b0;
            @(negedge clk);
            if (g < 4) req[gid] = 1'b1;
        end
        req = '0;
        wait_idle("rr_idle", 200);
        check("rr_nbytes", 32'(sent.size()), 32'd10);
        check("rr_no_timeout", 32'(to_count), 32'd0);

        // Timeout with transmitter never going busy
        mode = 1;
        sent.delete();
        req = 4'b0010;
        wait_ack("to_ack_wait", 10);
        check("to_gid", 32'(grant_id), 32'd1);
        req = '0;
        for (int i = 0; i < 100 && to_count == 0; i++) @(negedge clk);
        check("to_seen", 32'(to_count), 32'd1);
        check("to_latency", 32'(to_cyc - start_cyc), 32'd16);
        @(negedge clk);
        check("to_idle", 32'(sched_busy), 32'd0);
        repeat (5) @(negedge clk);
        check("to_nbytes", 32'(sent.size()), 32'd1);
        if (sent.size() == 1) check("to_hdr", 32'(sent[0]), 32'hA1);

        // Held busy after header; last_id kept at 1 so 0101 picks source 2
        mode = 2;
        sent.delete();
        req = 4'b0101;
        wait_ack("hb_ack_wait", 10);
        check("hb_gid", 32'(grant_id), 32'd2);
        req = '0;
        for (int i = 0; i < 10 && !tx_busy; i++) @(negedge clk);
        repeat (90) @(negedge clk);
        check("hb_busy", 32'(sched_busy), 32'd1);
        check("hb_txd", 32'(tx_data), 32'hA2);
        check("hb_start", 32'(tx_start), 32'd0);
        check("hb_no_timeout", 32'(to_count), 32'd1);
        check("hb_nbytes", 32'(sent.size()), 32'd1);
        mode = 0;
        for (int i = 0; i < 50 && sent.size() < 2; i++) @(negedge clk);
        check("hb_nbytes2", 32'(sent.size()), 32'd2);
        if (sent.size() == 2) check("hb_dat", 32'(sent[1]), 32'h3C);

        // Reset asserted while in WAIT_DAT_LO
        repeat (4) @(negedge clk);
        check("mr_pre", 32'({sched_busy, tx_busy}), 32'h3);
        #2 rst = 1'b0;
        #1 check_reset_vals("mr");
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 30 && tx_busy; i++) @(negedge clk);
        req = 4'b1001;
        wait_ack("mr_ack_wait", 10);
        check("mr_ack", 32'(ack), 32'h1);
        check("mr_gid", 32'(grant_id), 32'd0);
        req = '0;
        wait_idle("mr_idle", 100);
        check("stable_txd", 32'(stab_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
